// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared types and checks for the nibble-serial adder controller.
// State encoding plus the operand-width legality test.
package nibble_serial_adder_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIB_BITS = 4;

   function automatic bit width_ok(input int w);
      return ((w % NIB_BITS) == 0) && (w >= 8);
   endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle between producer, adder and consumer.
// master = producer/consumer side, slave = the controller.
interface nibble_serial_adder_ctrl_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c_in;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             c_out;
   logic             overflow;

   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, overflow
   );

   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, overflow
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl_fulladd4.sv
// 4-bit carry-lookahead adder (fulladd4), the shared nibble datapath.
// All carries are computed directly from generate/propagate terms.
module fulladd4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c_in,
   output logic [3:0] sum,
   output logic       c_out
);
   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a & b;
   assign p = a ^ b;

   assign c[0] = c_in;
   assign c[1] = g[0] | (p[0] & c_in);
   assign c[2] = g[1] | (p[1] & g[0])
               | (p[1] & p[0] & c_in);
   assign c[3] = g[2] | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & c_in);
   assign c_out = g[3] | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c_in);

   assign sum = p ^ c;
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer around one fulladd4.
// LSB nibble first; carry held in a register between passes.
module nibble_serial_adder_ctrl
   import nibble_serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input logic clock,
   input logic reset,
   nibble_serial_adder_ctrl_if.slave bus
);
   localparam int NIB = WIDTH / 4;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIB - 1);

   generate
      if (!width_ok(WIDTH)) begin : g_bad_width
         $error("WIDTH must be a multiple of 4 and at least 8");
      end
   endgenerate

   state_t state;
   state_t state_nx;

   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             a_msb;
   logic             beff_msb;
   logic             c_out_q;
   logic             ov_q;

   logic [3:0] nib_sum;
   logic       nib_co;
   logic       accept;
   logic       last;
   logic       in_ready_c;
   logic       out_valid_c;

   fulladd4 u_add (
      .a     (a_sh[3:0]),
      .b     (b_sh[3:0]),
      .c_in  (carry),
      .sum   (nib_sum),
      .c_out (nib_co)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (accept) state_nx = RUN;
         RUN:  if (last) state_nx = DONE;
         DONE: begin
            if (accept)             state_nx = RUN;
            else if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // in_ready sees out_ready combinationally so DONE can hand over directly
   always_comb begin
      in_ready_c  = (state == IDLE)
                  | ((state == DONE) & bus.out_ready);
      out_valid_c = (state == DONE);
      accept      = bus.in_valid & in_ready_c;
      last        = (state == RUN) & (idx == LAST);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx      <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         acc      <= '0;
         sum_q    <= '0;
         carry    <= 1'b0;
         a_msb    <= 1'b0;
         beff_msb <= 1'b0;
         c_out_q  <= 1'b0;
         ov_q     <= 1'b0;
      end else if (accept) begin
         idx      <= '0;
         a_sh     <= bus.a;
         b_sh     <= bus.sub ? ~bus.b : bus.b;
         carry    <= bus.sub ? 1'b1 : bus.c_in;
         a_msb    <= bus.a[WIDTH-1];
         beff_msb <= bus.sub ? ~bus.b[WIDTH-1]
                             : bus.b[WIDTH-1];
      end else if (state == RUN) begin
         a_sh  <= {4'b0, a_sh[WIDTH-1:4]};
         b_sh  <= {4'b0, b_sh[WIDTH-1:4]};
         acc   <= {nib_sum, acc[WIDTH-1:4]};
         carry <= nib_co;
         idx   <= idx + IW'(1);
         if (last) begin
            sum_q   <= {nib_sum, acc[WIDTH-1:4]};
            c_out_q <= nib_co;
            ov_q    <= (a_msb == beff_msb)
                     & (nib_sum[3] != a_msb);
         end
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.sum       = sum_q;
   assign bus.c_out     = c_out_q;
   assign bus.overflow  = ov_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl (WIDTH=16).
// Expected values are hand-computed constants.
module tb_nibble_serial_adder_ctrl;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;
   int   cyc;

   nibble_serial_adder_ctrl_if #(.WIDTH(16)) ifc ();

   nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic start(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic ci,
                        input logic s);
      @(negedge clk);
      ifc.in_valid = 1'b1;
      ifc.a        = a;
      ifc.b        = b;
      ifc.c_in     = ci;
      ifc.sub      = s;
      #1;
      check("in_ready_at_offer", 32'(ifc.in_ready), 1);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      check("out_valid_after_accept", 32'(ifc.out_valid), 0);
   endtask

   task automatic wait_done(input string tag,
                            input logic [15:0] es,
                            input logic eco,
                            input logic eov);
      int n;
      n = 0;
      while (!ifc.out_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_latency"}, 32'(n), 4);
      check({tag, "_sum"}, 32'(ifc.sum), 32'(es));
      check({tag, "_c_out"}, 32'(ifc.c_out), 32'(eco));
      check({tag, "_ovf"}, 32'(ifc.overflow), 32'(eov));
   endtask

   task automatic consume();
      @(negedge clk);
      ifc.out_ready = 1'b1;
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b0;
      check("out_valid_after_consume", 32'(ifc.out_valid), 0);
   endtask

   initial begin
      int t_prev;
      logic [15:0] va [3];
      logic [15:0] vb [3];
      logic [15:0] vs [3];
      logic        vo [3];
      n_chk  = 0;
      n_fail = 0;
      rst           = 1'b1;
      ifc.in_valid  = 1'b0;
      ifc.a         = '0;
      ifc.b         = '0;
      ifc.c_in      = 1'b0;
      ifc.sub       = 1'b0;
      ifc.out_ready = 1'b0;

      #12;
      check("rst_out_valid", 32'(ifc.out_valid), 0);
      check("rst_in_ready", 32'(ifc.in_ready), 1);
      check("rst_sum", 32'(ifc.sum), 0);
      check("rst_c_out", 32'(ifc.c_out), 0);
      check("rst_ovf", 32'(ifc.overflow), 0);
      @(negedge clk);
      rst = 1'b0;

      start(16'h1234, 16'h0FFF, 1'b0, 1'b0);
      wait_done("add1", 16'h2233, 1'b0, 1'b0);
      consume();

      start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done("ripple", 16'h0000, 1'b1, 1'b0);
      consume();

      start(16'h0005, 16'h0007, 1'b1, 1'b1);
      wait_done("sub1", 16'hFFFE, 1'b0, 1'b0);
      consume();

      start(16'h8000, 16'h0001, 1'b1, 1'b1);
      wait_done("sub2", 16'h7FFF, 1'b1, 1'b1);
      consume();

      // backpressure in DONE with competing operands offered
      start(16'h0100, 16'h0200, 1'b0, 1'b0);
      wait_done("bp", 16'h0300, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         ifc.in_valid = 1'b1;
         ifc.a        = 16'h1000 + 16'(i);
         ifc.b        = 16'h2000;
         #1;
         check("bp_in_ready", 32'(ifc.in_ready), 0);
         @(posedge clk);
         #1;
         check("bp_out_valid", 32'(ifc.out_valid), 1);
         check("bp_sum_held", 32'(ifc.sum), 32'h0300);
      end
      @(negedge clk);
      ifc.a         = 16'h0011;
      ifc.b         = 16'h0022;
      ifc.out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", 32'(ifc.in_ready), 1);
      @(posedge clk);
      #1;
      ifc.in_valid  = 1'b0;
      ifc.out_ready = 1'b0;
      check("bp_handover_out_valid", 32'(ifc.out_valid), 0);
      wait_done("bp_next", 16'h0033, 1'b0, 1'b0);
      consume();

      // asynchronous abort at idx==2
      start(16'hAAAA, 16'h1111, 1'b0, 1'b0);
      check("abort_prev_sum", 32'(ifc.sum), 32'h0033);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("abort_sum", 32'(ifc.sum), 0);
      check("abort_c_out", 32'(ifc.c_out), 0);
      check("abort_ovf", 32'(ifc.overflow), 0);
      check("abort_out_valid", 32'(ifc.out_valid), 0);
      check("abort_in_ready", 32'(ifc.in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      start(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_done("post_abort", 16'h0002, 1'b0, 1'b0);
      consume();

      // back-to-back with out_ready tied high
      va[0] = 16'h0001; vb[0] = 16'h0002;
      vs[0] = 16'h0003; vo[0] = 1'b0;
      va[1] = 16'h00FF; vb[1] = 16'h0001;
      vs[1] = 16'h0100; vo[1] = 1'b0;
      va[2] = 16'h7FFF; vb[2] = 16'h0001;
      vs[2] = 16'h8000; vo[2] = 1'b1;
      ifc.out_ready = 1'b1;
      t_prev = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ifc.in_valid = 1'b1;
         ifc.a        = va[k];
         ifc.b        = vb[k];
         ifc.c_in     = 1'b0;
         ifc.sub      = 1'b0;
         #1;
         check("b2b_in_ready", 32'(ifc.in_ready), 1);
         @(posedge clk);
         #1;
         if (k > 0)
            check("b2b_spacing", 32'(cyc - t_prev), 5);
         t_prev = cyc;
         wait_done("b2b", vs[k], 1'b0, vo[k]);
      end
      @(negedge clk);
      ifc.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("b2b_drain", 32'(ifc.out_valid), 0);
      ifc.out_ready = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
